// File: rtl/multicycle_control.sv
// Main sequencing FSM for the multicycle LEGv8 core.
// Decodes the latched instruction and, each cycle, drives the datapath load
// enables, mux selects, ALU operation, immediate format and the data-memory
// req/ready handshake. Also counts retired instructions.
module multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [31:0]      instr,
   input  logic             mem_ready,
   input  logic             zero,
   input  logic             flag_n,
   input  logic             flag_v,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_sel,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             reg_write,
   output logic             wb_sel,
   output logic             alu_src_b,
   output logic [2:0]       alu_op,
   output logic [2:0]       imm_sel,
   output logic             flag_write,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_START, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
   } state_t;

   typedef enum logic [3:0] {
      OP_ADDI, OP_ADDS, OP_SUBS, OP_AND, OP_EOR, OP_LSR,
      OP_LDUR, OP_STUR, OP_B, OP_BLT, OP_CBZ, OP_ILL
   } opc_t;

   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd1;
   localparam logic [2:0] ALU_AND   = 3'd2;
   localparam logic [2:0] ALU_EOR   = 3'd3;
   localparam logic [2:0] ALU_LSR   = 3'd4;
   localparam logic [2:0] ALU_PASSB = 3'd5;

   localparam logic [2:0] IMM_SHAMT = 3'd0;
   localparam logic [2:0] IMM_D     = 3'd1;
   localparam logic [2:0] IMM_I     = 3'd2;
   localparam logic [2:0] IMM_CB    = 3'd3;
   localparam logic [2:0] IMM_B     = 3'd4;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   opc_t       opc;
   logic [2:0] dec_imm_sel;
   logic [2:0] dec_alu_op;
   logic       dec_alu_src_b;
   logic       dec_sets_flags;

   // Classify the IR contents into one opcode; anything unmatched is illegal.
   always_comb begin
      opc = OP_ILL;
      if (instr[31:22] == 10'b1001000100) begin
         opc = OP_ADDI;
      end else if (instr[31:21] == 11'b10101011000) begin
         opc = OP_ADDS;
      end else if (instr[31:21] == 11'b11101011000) begin
         opc = OP_SUBS;
      end else if (instr[31:21] == 11'b10001010000) begin
         opc = OP_AND;
      end else if (instr[31:21] == 11'b11001010000) begin
         opc = OP_EOR;
      end else if (instr[31:21] == 11'b11010011010) begin
         opc = OP_LSR;
      end else if (instr[31:21] == 11'b11111000010) begin
         opc = OP_LDUR;
      end else if (instr[31:21] == 11'b11111000000) begin
         opc = OP_STUR;
      end else if (instr[31:26] == 6'b000101) begin
         opc = OP_B;
      end else if (instr[31:24] == 8'b01010100 && instr[4:0] == 5'b01011) begin
         opc = OP_BLT;
      end else if (instr[31:24] == 8'b10110100) begin
         opc = OP_CBZ;
      end
   end

   // Per-opcode immediate format and ALU setup, held from EXEC through WB.
   always_comb begin
      dec_imm_sel    = IMM_SHAMT;
      dec_alu_op     = ALU_ADD;
      dec_alu_src_b  = 1'b0;
      dec_sets_flags = 1'b0;
      case (opc)
         OP_ADDI: begin
            dec_imm_sel   = IMM_I;
            dec_alu_src_b = 1'b1;
         end
         OP_ADDS: dec_sets_flags = 1'b1;
         OP_SUBS: begin
            dec_alu_op     = ALU_SUB;
            dec_sets_flags = 1'b1;
         end
         OP_AND:  dec_alu_op = ALU_AND;
         OP_EOR:  dec_alu_op = ALU_EOR;
         OP_LSR: begin
            dec_alu_op    = ALU_LSR;
            dec_alu_src_b = 1'b1;
         end
         OP_LDUR, OP_STUR: begin
            dec_imm_sel   = IMM_D;
            dec_alu_src_b = 1'b1;
         end
         OP_B:    dec_imm_sel = IMM_B;
         OP_BLT:  dec_imm_sel = IMM_CB;
         OP_CBZ: begin
            dec_imm_sel = IMM_CB;
            dec_alu_op  = ALU_PASSB;
         end
         default: ;
      endcase
   end

   // Next-state and control outputs; every output defaults to 0 each cycle.
   always_comb begin
      state_d      = state_q;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      reg_write    = 1'b0;
      wb_sel       = 1'b0;
      alu_src_b    = 1'b0;
      alu_op       = ALU_ADD;
      imm_sel      = IMM_SHAMT;
      flag_write   = 1'b0;
      illegal      = 1'b0;
      case (state_q)
         S_START: state_d = S_FETCH;
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            imm_sel = dec_imm_sel;
            if (opc == OP_B) begin
               pc_write = 1'b1;
               pc_src   = 1'b1;
               state_d  = S_FETCH;
            end else if (opc == OP_ILL) begin
               illegal  = 1'b1;
               pc_write = 1'b1;
               state_d  = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            imm_sel   = dec_imm_sel;
            alu_op    = dec_alu_op;
            alu_src_b = dec_alu_src_b;
            case (opc)
               OP_LDUR, OP_STUR: state_d = S_MEM;
               OP_CBZ: begin
                  pc_write = 1'b1;
                  pc_src   = zero;
                  state_d  = S_FETCH;
               end
               OP_BLT: begin
                  pc_write = 1'b1;
                  pc_src   = flag_n ^ flag_v;
                  state_d  = S_FETCH;
               end
               OP_ADDI, OP_ADDS, OP_SUBS, OP_AND, OP_EOR, OP_LSR: begin
                  flag_write = dec_sets_flags;
                  state_d    = S_WB;
               end
               default: state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = (opc == OP_STUR);
            imm_sel      = dec_imm_sel;
            alu_op       = dec_alu_op;
            alu_src_b    = dec_alu_src_b;
            if (mem_ready) begin
               if (opc == OP_LDUR) begin
                  state_d = S_WB;
               end else begin
                  pc_write = 1'b1;
                  state_d  = S_FETCH;
               end
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            wb_sel    = (opc == OP_LDUR);
            pc_write  = 1'b1;
            imm_sel   = dec_imm_sel;
            alu_op    = dec_alu_op;
            alu_src_b = dec_alu_src_b;
            state_d   = S_FETCH;
         end
         default: state_d = S_START;
      endcase
   end

   // An instruction retires on every legal PC update; the count wraps.
   always_comb begin
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, (pc_write & ~illegal)};
   end

   // State and retired-count registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_START;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver applies one cycle of
// directed inputs and queues the hand-computed control vector for that cycle;
// an independent monitor pops and compares on the falling edge.
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] instr = '0;
   logic        mem_ready = 1'b0;
   logic        zero = 1'b0;
   logic        flag_n = 1'b0;
   logic        flag_v = 1'b0;
   logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src;
   logic        reg_write, wb_sel, alu_src_b, flag_write, illegal;
   logic [2:0]  alu_op, imm_sel;
   logic [31:0] retired;

   multicycle_control #(.CNT_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .instr(instr), .mem_ready(mem_ready),
      .zero(zero), .flag_n(flag_n), .flag_v(flag_v),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .imm_sel(imm_sel), .flag_write(flag_write),
      .illegal(illegal), .retired(retired)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] I_ADDI = 32'h910017E1;
   localparam logic [31:0] I_LDUR = 32'hF8400020;
   localparam logic [31:0] I_STUR = 32'hF8000020;
   localparam logic [31:0] I_SUBS = 32'hEB030041;
   localparam logic [31:0] I_ADDS = 32'hAB030041;
   localparam logic [31:0] I_AND  = 32'h8A030041;
   localparam logic [31:0] I_EOR  = 32'hCA030041;
   localparam logic [31:0] I_LSR  = 32'hD3400C41;
   localparam logic [31:0] I_BLT  = 32'h5400004B;
   localparam logic [31:0] I_BEQ  = 32'h54000040;
   localparam logic [31:0] I_CBZ  = 32'hB4000061;
   localparam logic [31:0] I_B    = 32'h14000003;
   localparam logic [31:0] I_ZERO = 32'h00000000;

   typedef struct packed {
      logic [16:0] ctl;
      logic [31:0] ret;
      logic [31:0] cyc;
   } exp_t;

   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   logic [31:0] exp_ret = '0;

   // {req, we, addr_sel, ir_write, pc_write, pc_src, reg_write, wb_sel,
   //  alu_src_b, alu_op[2:0], imm_sel[2:0], flag_write, illegal}
   function automatic logic [16:0] mk(input logic req, we, asel, irw, pcw,
                                       pcs, rw, wbs, srcb,
                                       input logic [2:0] op, imm,
                                       input logic fw, ill);
      return {req, we, asel, irw, pcw, pcs, rw, wbs, srcb, op, imm, fw, ill};
   endfunction

   function automatic logic [16:0] fx(input logic rdy);
      return mk(1, 0, 0, rdy, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0, 0);
   endfunction

   task automatic step(input logic rst, input logic [31:0] ins, input logic rdy,
                       input logic z, input logic n, input logic v,
                       input logic [16:0] exp);
      exp_t e;
      @(posedge clk);
      #1;
      reset_n   = rst;
      instr     = ins;
      mem_ready = rdy;
      zero      = z;
      flag_n    = n;
      flag_v    = v;
      if (!rst) exp_ret = '0;
      e.ctl = exp;
      e.ret = exp_ret;
      e.cyc = cyc;
      sb_q.push_back(e);
      if (rst && exp[12] && !exp[0]) exp_ret = exp_ret + 32'd1;
      cyc++;
   endtask

   // Four-cycle R/I instruction with zero-wait fetch.
   task automatic alu_instr(input logic [31:0] ins, input logic [2:0] op,
                            input logic srcb, input logic [2:0] imm,
                            input logic fw);
      step(1, ins, 1, 0, 0, 0, fx(1));
      step(1, ins, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0,3'd0,imm,0,0));
      step(1, ins, 1, 0, 0, 0, mk(0,0,0,0,0,0,0,0,srcb,op,imm,fw,0));
      step(1, ins, 0, 0, 0, 0, mk(0,0,0,0,1,0,1,0,srcb,op,imm,0,0));
   endtask

   // Three-cycle conditional branch; the condition inputs matter only in EXEC.
   task automatic cond_br(input logic [31:0] ins, input logic z, input logic n,
                          input logic v, input logic [2:0] op,
                          input logic pcs);
      step(1, ins, 1, 0, 0, 0, fx(1));
      step(1, ins, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0,3'd0,3'd3,0,0));
      step(1, ins, 0, z, n, v, mk(0,0,0,0,1,pcs,0,0,0,op,3'd3,0,0));
   endtask

   // Monitor: compare the DUT against the oldest queued expectation.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t        e;
         logic [16:0] act;
         e   = sb_q.pop_front();
         act = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                reg_write, wb_sel, alu_src_b, alu_op, imm_sel, flag_write,
                illegal};
         n_cmp++;
         if (act !== e.ctl) begin
            n_bad++;
            $display("FAIL ctl cycle %0d: got %b required %b", e.cyc, act, e.ctl);
         end
         n_cmp++;
         if (retired !== e.ret) begin
            n_bad++;
            $display("FAIL retired cycle %0d: got %0d required %0d",
                     e.cyc, retired, e.ret);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset, then ADDI X1,X31,#5: START, F, D, E, WB
      step(0, I_ADDI, 0, 0, 0, 0, 17'd0);
      step(0, I_ADDI, 1, 0, 0, 0, 17'd0);
      step(1, I_ADDI, 1, 0, 0, 0, 17'd0);
      alu_instr(I_ADDI, 3'd0, 1, 3'd2, 0);

      // LDUR with three wait states in FETCH and in MEM (11 cycles)
      step(1, I_LDUR, 0, 0, 0, 0, fx(0));
      step(1, I_LDUR, 0, 0, 0, 0, fx(0));
      step(1, I_LDUR, 0, 0, 0, 0, fx(0));
      step(1, I_LDUR, 1, 0, 0, 0, fx(1));
      step(1, I_LDUR, 1, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0,3'd0,3'd1,0,0));
      step(1, I_LDUR, 1, 0, 0, 0, mk(0,0,0,0,0,0,0,0,1,3'd0,3'd1,0,0));
      step(1, I_LDUR, 0, 0, 0, 0, mk(1,0,1,0,0,0,0,0,1,3'd0,3'd1,0,0));
      step(1, I_LDUR, 0, 0, 0, 0, mk(1,0,1,0,0,0,0,0,1,3'd0,3'd1,0,0));
      step(1, I_LDUR, 0, 0, 0, 0, mk(1,0,1,0,0,0,0,0,1,3'd0,3'd1,0,0));
      step(1, I_LDUR, 1, 0, 0, 0, mk(1,0,1,0,0,0,0,0,1,3'd0,3'd1,0,0));
      step(1, I_LDUR, 0, 0, 0, 0, mk(0,0,0,0,1,0,1,1,1,3'd0,3'd1,0,0));

      // SUBS (N=1, V=0) then B.LT taken; repeat with N=V=0 and N=0,V=1
      alu_instr(I_SUBS, 3'd1, 0, 3'd0, 1);
      cond_br(I_BLT, 0, 1, 0, 3'd0, 1);
      alu_instr(I_SUBS, 3'd1, 0, 3'd0, 1);
      cond_br(I_BLT, 0, 0, 0, 3'd0, 0);
      cond_br(I_BLT, 0, 0, 1, 3'd0, 1);
      cond_br(I_BLT, 0, 1, 1, 3'd0, 0);

      // Remaining ALU opcodes
      alu_instr(I_ADDS, 3'd0, 0, 3'd0, 1);
      alu_instr(I_AND,  3'd2, 0, 3'd0, 0);
      alu_instr(I_EOR,  3'd3, 0, 3'd0, 0);
      alu_instr(I_LSR,  3'd4, 1, 3'd0, 0);

      // CBZ taken then not taken
      cond_br(I_CBZ, 1, 0, 0, 3'd5, 1);
      cond_br(I_CBZ, 0, 0, 0, 3'd5, 0);

      // Unconditional B: two cycles
      step(1, I_B, 1, 0, 0, 0, fx(1));
      step(1, I_B, 0, 0, 0, 0, mk(0,0,0,0,1,1,0,0,0,3'd0,3'd4,0,0));

      // Illegal encodings: all-zero word and B.EQ
      step(1, I_ZERO, 1, 0, 0, 0, fx(1));
      step(1, I_ZERO, 0, 0, 0, 0, mk(0,0,0,0,1,0,0,0,0,3'd0,3'd0,0,1));
      step(1, I_BEQ, 1, 0, 0, 0, fx(1));
      step(1, I_BEQ, 0, 0, 0, 0, mk(0,0,0,0,1,0,0,0,0,3'd0,3'd0,0,1));

      // STUR with reset dropped during a MEM wait, then restart
      step(1, I_STUR, 1, 0, 0, 0, fx(1));
      step(1, I_STUR, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0,3'd0,3'd1,0,0));
      step(1, I_STUR, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0,1,3'd0,3'd1,0,0));
      step(1, I_STUR, 0, 0, 0, 0, mk(1,1,1,0,0,0,0,0,1,3'd0,3'd1,0,0));
      step(1, I_STUR, 0, 0, 0, 0, mk(1,1,1,0,0,0,0,0,1,3'd0,3'd1,0,0));
      step(0, I_STUR, 1, 0, 0, 0, 17'd0);
      step(1, I_STUR, 1, 0, 0, 0, 17'd0);
      step(1, I_STUR, 1, 0, 0, 0, fx(1));
      step(1, I_STUR, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0,3'd0,3'd1,0,0));
      step(1, I_STUR, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0,1,3'd0,3'd1,0,0));
      step(1, I_STUR, 1, 0, 0, 0, mk(1,1,1,0,1,0,0,0,1,3'd0,3'd1,0,0));
      step(1, I_ADDI, 0, 0, 0, 0, fx(0));

      @(negedge clk);
      #1;
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard drain: got %0d pending required 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
